// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared types and width constants for the sequential divider
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_DEFAULT = 16;

  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int CNT_W = cnt_width(N_DEFAULT);

endpackage

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one combinational restoring-division iteration
module div_step
  import seq_divider_pkg::*;
#(
  parameter int n = N_DEFAULT
) (
  input  logic [n:0]   r,
  input  logic [n-1:0] q,
  input  logic [n-1:0] divisor,
  output logic [n:0]   r_next,
  output logic [n-1:0] q_next
);

  logic [n+1:0] wide;
  logic [n+1:0] diff;
  logic         borrow;

  // One guard bit above R makes the borrow of the trial subtract explicit.
  assign wide   = {r, q[n-1]};
  assign diff   = wide - {2'b00, divisor};
  assign borrow = diff[n+1];

  assign r_next = borrow ? wide[n:0] : diff[n:0];
  assign q_next = {q[n-2:0], ~borrow};

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - n-cycle unsigned restoring divider with start/valid handshake
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int n = N_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder,
  output logic         valid,
  output logic         busy,
  output logic         div_by_zero
);

  localparam int            CW   = cnt_width(n);
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  state_t         state;
  state_t         next_state;
  logic [n:0]     r_reg;
  logic [n-1:0]   q_reg;
  logic [n-1:0]   dvs_reg;
  logic [CW-1:0]  count;
  logic [n:0]     r_next;
  logic [n-1:0]   q_next;
  logic           zero_div;

  div_step #(.n(n)) u_step (
    .r       (r_reg),
    .q       (q_reg),
    .divisor (dvs_reg),
    .r_next  (r_next),
    .q_next  (q_next)
  );

  assign zero_div = (divisor == '0);
  assign valid    = (state == DONE);
  assign busy     = (state == RUN);

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (start) next_state = zero_div ? DONE : RUN;
        else       next_state = IDLE;
      end
      RUN: begin
        if (count == LAST) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      r_reg       <= '0;
      q_reg       <= '0;
      dvs_reg     <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= next_state;
      if (state == RUN) begin
        r_reg <= r_next;
        q_reg <= q_next;
        count <= count + CW'(1);
        // The last iteration lands straight in the result registers.
        if (count == LAST) begin
          quotient    <= q_next;
          remainder   <= r_next[n-1:0];
          div_by_zero <= 1'b0;
        end
      end else if (start) begin
        if (zero_div) begin
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
        end else begin
          r_reg   <= '0;
          q_reg   <= dividend;
          dvs_reg <= divisor;
          count   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed vector bench for seq_divider
module tb_seq_divider;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        valid;
  logic        busy;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[8];
  vec_t ops[3];

  seq_divider #(.n(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .valid       (valid),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Caller is at posedge+1; start is sampled on the next edge, which counts as edge 1.
  task automatic run_div(input vec_t v, input string tag);
    int edges;
    int busy_bad;
    busy_bad = 0;
    dividend = v.dividend;
    divisor  = v.divisor;
    start    = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    edges = 1;
    while (!valid && edges < 40) begin
      if (!busy) busy_bad++;
      @(posedge clock); #1;
      edges++;
    end
    if (busy) busy_bad++;
    check({tag, " latency"}, edges, v.lat);
    check({tag, " quotient"}, quotient, v.q);
    check({tag, " remainder"}, remainder, v.r);
    check({tag, " div_by_zero"}, div_by_zero, v.dbz);
    check({tag, " busy"}, busy_bad, 0);
    @(posedge clock); #1;
    check({tag, " valid one cycle"}, valid, 1'b0);
    check({tag, " quotient held"}, quotient, v.q);
  endtask

  initial begin
    int edges;
    int idx;
    int vhits;

    vecs[0] = '{16'hD4D4, 16'h9797, 16'h0001, 16'h3D3D, 1'b0, 17};
    vecs[1] = '{16'hDFDF, 16'h1515, 16'h000A, 16'h0D0D, 1'b0, 17};
    vecs[2] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17};
    vecs[3] = '{16'h0005, 16'h0007, 16'h0000, 16'h0005, 1'b0, 17};
    vecs[4] = '{16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1};
    vecs[5] = '{16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 17};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 17};
    vecs[7] = '{16'h8000, 16'h0003, 16'h2AAA, 16'h0002, 1'b0, 17};

    ops[0] = '{16'h9C40, 16'h0064, 16'h0190, 16'h0000, 1'b0, 17};
    ops[1] = '{16'hABCD, 16'h0123, 16'h0097, 16'h0028, 1'b0, 17};
    ops[2] = '{16'h0010, 16'h0003, 16'h0005, 16'h0001, 1'b0, 17};

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #25;
    reset = 1'b0;
    @(posedge clock); #1;
    check("reset quotient", quotient, 16'h0);
    check("reset remainder", remainder, 16'h0);
    check("reset valid", valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset div_by_zero", div_by_zero, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_div(vecs[i], $sformatf("vec%0d", i));
    end

    // start held high: each result lands 17 edges after the previous one
    idx      = 0;
    edges    = 0;
    dividend = ops[0].dividend;
    divisor  = ops[0].divisor;
    start    = 1'b1;
    while (idx < 3 && edges < 80) begin
      @(posedge clock); #1;
      edges++;
      if (valid) begin
        check($sformatf("b2b%0d latency", idx), edges, 17 * (idx + 1));
        check($sformatf("b2b%0d quotient", idx), quotient, ops[idx].q);
        check($sformatf("b2b%0d remainder", idx), remainder, ops[idx].r);
        idx++;
        if (idx < 3) begin
          dividend = ops[idx].dividend;
          divisor  = ops[idx].divisor;
        end else begin
          start = 1'b0;
        end
      end else if (busy) begin
        dividend = 16'hFFFF;
        divisor  = 16'h0001;
      end
    end
    check("b2b results seen", idx, 3);
    @(posedge clock); #1;
    check("b2b valid drops", valid, 1'b0);

    // reset 8 edges into a run aborts it silently
    dividend = 16'h7777;
    divisor  = 16'h0003;
    start    = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (7) @(posedge clock);
    #2;
    check("abort busy before reset", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("abort busy", busy, 1'b0);
    check("abort valid", valid, 1'b0);
    check("abort quotient", quotient, 16'h0);
    check("abort remainder", remainder, 16'h0);
    check("abort div_by_zero", div_by_zero, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    vhits = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clock); #1;
      if (valid || busy) vhits++;
    end
    check("abort no valid", vhits, 0);
    run_div(vecs[1], "post_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
